ram_block_copier: RTL and testbench
===================================

Name: ram_block_copier

Overview:
- Memory-bus initiator (DMA-style block copier) that drives the single-port synchronous RAM's address/load/in/out port.
- Copies `length` consecutive 16-bit words from `src_addr` to `dst_addr`, accounting for the RAM's 1-cycle registered read latency.
- Sits between the Hack CPU-side control logic (start/length registers) and the data RAM port. It replaces CPU loops for screen clears and buffer moves.

Parameters:
- ADDR_WIDTH, 16, RAM address width; must match the attached RAM instance.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- abort  in  1  cancel current transfer.
- src_addr  in  ADDR_WIDTH  first source word address.
- dst_addr  in  ADDR_WIDTH  first destination word address.
- length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse on normal completion.
- words_done  out  ADDR_WIDTH+1  words written so far in the current/last transfer.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_load  out  1  RAM write enable.
- mem_in  out  16  RAM write data.
- mem_out  in  16  RAM read data; valid the cycle after the address is presented with mem_load=0.

Behaviour:
- Async reset (rst_n=0), applied immediately regardless of state:
  - state=IDLE; busy=0, done=0, mem_load=0, mem_address=0, mem_in=0.
  - words_done=0; internal src/dst/remaining counters=0.
- States: IDLE, READ, WRITE, FINISH.
- IDLE:
  - mem_load=0.
  - start=1 latches src_addr, dst_addr and length, clears words_done.
  - Next state is READ if length!=0, else FINISH.
  - start while busy is ignored.
- READ (1 cycle):
  - mem_address=src counter, mem_load=0.
  - Next state: WRITE.
- WRITE (1 cycle):
  - mem_address=dst counter, mem_load=1, mem_in=mem_out (the word read in the previous cycle, passed straight through).
  - At the edge: src+1, dst+1, remaining-1, words_done+1.
  - Next state: FINISH if remaining was 1, else READ.
- FINISH (1 cycle):
  - done=1, mem_load=0.
  - Next state: IDLE.
- busy=1 in READ, WRITE and FINISH; busy=0 in IDLE.
- Throughput and latency:
  - 2 cycles per word.
  - done asserts 2*length+1 cycles after the start edge, or 1 cycle after it for length=0.
- mem_address, mem_load and mem_in are combinational from state and counters. mem_load is never high outside WRITE.
- Address arithmetic is modulo 2^ADDR_WIDTH; src and dst wrap independently (0xFFFF+1 -> 0x0000 at ADDR_WIDTH=16).
- length=2^ADDR_WIDTH copies the entire memory.
- Overlap is strictly word-by-word forward:
  - dst in (src, src+length) replicates data.
  - dst==src rewrites identical data.
  - Both are defined behaviour, not errors.
- abort in READ or WRITE:
  - The write presented in that cycle (if WRITE) still completes.
  - Next state is IDLE with no done pulse.
  - words_done holds the count including that write.
- abort in IDLE or FINISH has no effect. When start and abort are both high in IDLE, start wins.
- mem_out is ignored in every state except WRITE.

Optional Feature:
- Macro: RAM_BLOCK_COPIER_FILL_EN.
- When defined:
  - Adds inputs fill_mode (1) and fill_value (16), both latched at start.
  - With fill_mode=1, the transfer skips READ: states cycle WRITE->WRITE with mem_in=fill_value, at 1 cycle per word.
  - done follows length+1 cycles after start.
  - src_addr is ignored.
- When undefined: the ports do not exist and behaviour is copy-only.

Test Plan:
- RAM[0x0010..0x0013]=0xA000..0xA003; start with src=0x0010, dst=0x0100, len=4 -> RAM[0x0100..0x0103]=0xA000..0xA003, done pulses exactly at cycle 9 after start, words_done=4, busy=0 afterward.
- start with len=0 -> no mem_load ever asserted, done pulses at cycle 1, words_done=0.
- src=0xFFFE, dst=0x0000, len=3, RAM[0xFFFE]=1, RAM[0xFFFF]=2, RAM[0x0000]=3 -> RAM[0x0000]=1, RAM[0x0001]=2, RAM[0x0002]=1; src wrap verified; done at cycle 7.
- len=8 copy, abort asserted in the 3rd WRITE cycle -> exactly 3 destination words written, no done pulse, words_done=3, IDLE next cycle; then start during busy of a new transfer is ignored.
- rst_n pulled low mid-WRITE -> mem_load drops to 0 without waiting for clk, busy=0; after release, a new len=2 copy completes normally.
- (RAM_BLOCK_COPIER_FILL_EN) fill_mode=1, fill_value=0x0000, dst=0x4000, len=8192 -> screen region zeroed, done at cycle 8193, no read cycles observed.

Source files
------------

// File: rtl/ram_block_copier_if.sv
// RAM port bundle between the block copier (master) and the single-port data RAM (slave).
interface ram_block_copier_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_load;
    logic [15:0]           mem_in;
    logic [15:0]           mem_out;

    modport master (
        output mem_address,
        output mem_load,
        output mem_in,
        input  mem_out
    );

    modport slave (
        input  mem_address,
        input  mem_load,
        input  mem_in,
        output mem_out
    );
endinterface

// File: rtl/ram_block_copier.sv
// DMA-style block copier driving a single-port synchronous RAM (1-cycle read latency).
// Optional constant-fill mode is enabled by defining RAM_BLOCK_COPIER_FILL_EN.
module ram_block_copier #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef RAM_BLOCK_COPIER_FILL_EN
    input  logic                  fill_mode,
    input  logic [15:0]           fill_value,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_done,
    ram_block_copier_if.master    mem
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] READ   = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic [15:0]           write_data;
    logic                  fill_on;
    logic                  start_fill;

`ifdef RAM_BLOCK_COPIER_FILL_EN
    logic        fill_q;
    logic [15:0] fill_value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q       <= 1'b0;
            fill_value_q <= '0;
        end else if (state == IDLE && start) begin
            fill_q       <= fill_mode;
            fill_value_q <= fill_value;
        end
    end

    assign fill_on    = fill_q;
    assign start_fill = fill_mode;
    assign write_data = fill_q ? fill_value_q : mem.mem_out;
`else
    assign fill_on    = 1'b0;
    assign start_fill = 1'b0;
    assign write_data = mem.mem_out;
`endif

    // Abort has priority over completion so an aborted last word never produces done.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0)
                        state_nxt = FINISH;
                    else if (start_fill)
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = abort ? IDLE : WRITE;
            end
            WRITE: begin
                if (abort)
                    state_nxt = IDLE;
                else if (remaining_q == LAST_WORD)
                    state_nxt = FINISH;
                else if (fill_on)
                    state_nxt = WRITE;
                else
                    state_nxt = READ;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            words_done  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                src_q       <= src_addr;
                dst_q       <= dst_addr;
                remaining_q <= length;
                words_done  <= '0;
            end else if (state == WRITE) begin
                // The write in this cycle completes even when aborted, so counters still advance.
                src_q       <= src_q + 1'b1;
                dst_q       <= dst_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
                words_done  <= words_done + 1'b1;
            end
        end
    end

    always_comb begin
        mem.mem_address = '0;
        mem.mem_load    = 1'b0;
        mem.mem_in      = '0;
        case (state)
            READ: begin
                mem.mem_address = src_q;
            end
            WRITE: begin
                mem.mem_address = dst_q;
                mem.mem_load    = 1'b1;
                mem.mem_in      = write_data;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

endmodule

// File: tb/tb_ram_block_copier.sv
// Directed self-checking bench for ram_block_copier with a behavioural 1-cycle-latency RAM.
module tb_ram_block_copier;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic [AW:0]   words_done;
`ifdef RAM_BLOCK_COPIER_FILL_EN
    logic          fill_mode = 1'b0;
    logic [15:0]   fill_value = '0;
`endif

    ram_block_copier_if #(.ADDR_WIDTH(AW)) mem_bus ();

    ram_block_copier #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
`ifdef RAM_BLOCK_COPIER_FILL_EN
        .fill_mode  (fill_mode),
        .fill_value (fill_value),
`endif
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .mem        (mem_bus.master)
    );

    always #5 clk = ~clk;

    logic [15:0] ram     [0:65535] = '{default: 16'h0000};
    logic [15:0] ref_ram [0:65535] = '{default: 16'h0000};
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = '0;
    logic [15:0] poke_data = '0;
    int unsigned load_cycles = 0;
    int unsigned read_cycles = 0;

    always @(posedge clk) begin
        if (poke_en)
            ram[poke_addr] <= poke_data;
        else if (mem_bus.mem_load)
            ram[mem_bus.mem_address] <= mem_bus.mem_in;
        mem_bus.mem_out <= ram[mem_bus.mem_address];
        if (mem_bus.mem_load) load_cycles <= load_cycles + 1;
        if (busy && !mem_bus.mem_load && !done) read_cycles <= read_cycles + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
        ref_ram[a] = v;
    endtask

    task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n,
                              input bit fill, input logic [15:0] fv);
        logic [15:0] sa, da;
        sa = s; da = d;
        for (int i = 0; i < n; i++) begin
            ref_ram[da] = fill ? fv : ref_ram[sa];
            sa = sa + 16'd1;
            da = da + 16'd1;
        end
    endtask

    task automatic check_range(input string name, input logic [15:0] d, input int n);
        int mism;
        logic [15:0] a;
        mism = 0;
        a = d - 16'd1;
        for (int i = -1; i <= n; i++) begin
            if (ram[a] !== ref_ram[a]) mism++;
            a = a + 16'd1;
        end
        check(name, mism, 0);
    endtask

    // Runs one transfer; cycle 1 is the first cycle after the start edge.
    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [16:0] l,
                            input int abort_at, input int glitch_at, input bit abort_with_start,
                            output int done_cyc, output int idle_cyc,
                            output int nwrites, output int nreads);
        int unsigned l0, r0;
        int w, budget;
        l0 = load_cycles; r0 = read_cycles;
        budget = 2 * int'(l) + 20;
        done_cyc = -1; idle_cyc = -1; w = 0;
        @(negedge clk);
        src_addr = s; dst_addr = d; length = l; start = 1'b1; abort = abort_with_start;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (done) begin done_cyc = c; break; end
            if (!busy) begin idle_cyc = c; break; end
            if (c == glitch_at) begin
                start = 1'b1; src_addr = s + 16'h0100; dst_addr = 16'h0A00; length = 17'd1;
            end
            if (mem_bus.mem_load) begin
                w++;
                if (w == abort_at) abort = 1'b1;
            end
        end
        nwrites = int'(load_cycles - l0);
        nreads = int'(read_cycles - r0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] src;
        logic [15:0] dst;
        logic [16:0] len;
        int          exp_cyc;
        int          exp_words;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, ic, nw, nr;

        vecs[0] = '{"copy4",     16'h0010, 16'h0100, 17'd4, 9, 4};
        vecs[1] = '{"len0",      16'h0020, 16'h0200, 17'd0, 1, 0};
        vecs[2] = '{"src_wrap",  16'hFFFE, 16'h0000, 17'd3, 7, 3};
        vecs[3] = '{"overlap",   16'h0300, 16'h0301, 17'd4, 9, 4};
        vecs[4] = '{"same",      16'h0400, 16'h0400, 17'd2, 5, 2};
        vecs[5] = '{"dst_wrap",  16'h0500, 16'hFFFF, 17'd2, 5, 2};

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_load", mem_bus.mem_load, 0);
        check("rst_addr", mem_bus.mem_address, 0);
        check("rst_in", mem_bus.mem_in, 0);
        check("rst_words", words_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) poke(16'h0010 + 16'(i), 16'hA000 + 16'(i));
        poke(16'hFFFE, 16'd1); poke(16'hFFFF, 16'd2); poke(16'h0000, 16'd3);
        poke(16'h0300, 16'h1111); poke(16'h0301, 16'h2222); poke(16'h0302, 16'h3333);
        poke(16'h0303, 16'h4444); poke(16'h0304, 16'h5555);
        poke(16'h0400, 16'hCAFE); poke(16'h0401, 16'hBEEF);
        poke(16'h0500, 16'h0F0F); poke(16'h0501, 16'hF0F0);
        for (int i = 0; i < 8; i++) poke(16'h0600 + 16'(i), 16'h6000 + 16'(i));
        for (int i = 0; i < 3; i++) poke(16'h0800 + 16'(i), 16'h8000 + 16'(i));
        for (int i = 0; i < 4; i++) poke(16'h0B00 + 16'(i), 16'hB000 + 16'(i));
        poke(16'h0D00, 16'hD0D0); poke(16'h0D01, 16'hD1D1);
        poke(16'h3FFF, 16'h7777); poke(16'h4000, 16'hFFFF);
        poke(16'h5FFF, 16'h1234); poke(16'h6000, 16'h5555);

        for (int i = 0; i < NV; i++) begin
            run_xfer(vecs[i].src, vecs[i].dst, vecs[i].len, 0, 0, 1'b0, dc, ic, nw, nr);
            model_copy(vecs[i].src, vecs[i].dst, int'(vecs[i].len), 1'b0, 16'h0);
            check({vecs[i].name, "_done_cyc"}, dc, vecs[i].exp_cyc);
            check({vecs[i].name, "_words"}, words_done, vecs[i].exp_words);
            check({vecs[i].name, "_writes"}, nw, vecs[i].exp_words);
            check_range({vecs[i].name, "_data"}, vecs[i].dst, int'(vecs[i].len));
            if (i == 0) check("copy4_word3", ram[16'h0103], 16'hA003);
            if (i == 2) begin
                check("wrap_ram0", ram[16'h0000], 16'd1);
                check("wrap_ram1", ram[16'h0001], 16'd2);
                check("wrap_ram2", ram[16'h0002], 16'd1);
            end
            if (i == 3) check("overlap_rep", ram[16'h0304], 16'h1111);
            @(negedge clk);
            check({vecs[i].name, "_busy_after"}, busy, 0);
        end

        // Abort during the 3rd WRITE: that write lands, then straight to IDLE.
        run_xfer(16'h0600, 16'h0700, 17'd8, 3, 0, 1'b0, dc, ic, nw, nr);
        model_copy(16'h0600, 16'h0700, 3, 1'b0, 16'h0);
        check("abort_no_done", dc, -1);
        check("abort_idle_cyc", ic, 7);
        check("abort_writes", nw, 3);
        check("abort_words", words_done, 3);
        check_range("abort_data", 16'h0700, 8);

        // Second start while busy must be ignored.
        run_xfer(16'h0800, 16'h0900, 17'd3, 0, 2, 1'b0, dc, ic, nw, nr);
        model_copy(16'h0800, 16'h0900, 3, 1'b0, 16'h0);
        check("ignore_done_cyc", dc, 7);
        check("ignore_words", words_done, 3);
        check_range("ignore_data", 16'h0900, 3);
        check_range("ignore_glitch_dst", 16'h0A00, 1);

        // start and abort together in IDLE: start wins.
        run_xfer(16'h0010, 16'h1000, 17'd2, 0, 0, 1'b1, dc, ic, nw, nr);
        model_copy(16'h0010, 16'h1000, 2, 1'b0, 16'h0);
        check("startabort_done_cyc", dc, 5);
        check("startabort_words", words_done, 2);
        check_range("startabort_data", 16'h1000, 2);

        // Asynchronous reset in the middle of a WRITE cycle.
        @(negedge clk);
        src_addr = 16'h0B00; dst_addr = 16'h0C00; length = 17'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_pre_load", mem_bus.mem_load, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_load", mem_bus.mem_load, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_words", words_done, 0);
        check("rst_mid_addr", mem_bus.mem_address, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_range("rst_mid_nowrite", 16'h0C00, 4);
        run_xfer(16'h0D00, 16'h0E00, 17'd2, 0, 0, 1'b0, dc, ic, nw, nr);
        model_copy(16'h0D00, 16'h0E00, 2, 1'b0, 16'h0);
        check("post_rst_done_cyc", dc, 5);
        check("post_rst_words", words_done, 2);
        check_range("post_rst_data", 16'h0E00, 2);

`ifdef RAM_BLOCK_COPIER_FILL_EN
        fill_mode = 1'b1; fill_value = 16'h0000;
        run_xfer(16'h0010, 16'h4000, 17'd8192, 0, 0, 1'b0, dc, ic, nw, nr);
        fill_mode = 1'b0;
        model_copy(16'h0010, 16'h4000, 8192, 1'b1, 16'h0000);
        check("fill_done_cyc", dc, 8193);
        check("fill_reads", nr, 0);
        check("fill_words", words_done, 8192);
        check_range("fill_data", 16'h4000, 8192);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
